timer_irq: RTL and testbench

//  Wishbone-slave 32-bit timer with prescaler, compare match and periodic or one-shot mode.

---
 rtl/timer_irq_if.sv | 20 ++
 rtl/timer_irq.sv | 134 +++++++++++++
 tb/tb_timer_irq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/timer_irq_if.sv
// Wishbone-style register bus between a host and the timer_irq slave.
// Signal names follow the slave's point of view (i_ driven by the host, o_ by the timer).
interface timer_irq_if #(parameter int W = 32);
   logic         i_wb_cyc;
   logic [1:0]   i_wb_adr;
   logic [W-1:0] i_wb_dat;
   logic         i_wb_we;
   logic [W-1:0] o_wb_rdt;
   logic         o_wb_ack;

   modport master (
      output i_wb_cyc, i_wb_adr, i_wb_dat, i_wb_we,
      input  o_wb_rdt, o_wb_ack
   );

   modport slave (
      input  i_wb_cyc, i_wb_adr, i_wb_dat, i_wb_we,
      output o_wb_rdt, o_wb_ack
   );
endinterface

// File: rtl/timer_irq.sv
// Bus-programmable 32-bit timer with prescaler, compare match and periodic/one-shot modes.
// o_irq is a level held until software clears STATUS[0]; the interrupt controller edge-detects it.
module timer_irq #(
   parameter int W  = 32,
   parameter int PW = 8
) (
   input  logic        clk,
   input  logic        rstn,
   timer_irq_if.slave  bus,
   output logic        o_irq
);

   localparam logic [1:0] A_CTRL    = 2'd0;
   localparam logic [1:0] A_STATUS  = 2'd1;
   localparam logic [1:0] A_COMPARE = 2'd2;
   localparam logic [1:0] A_COUNT   = 2'd3;

   logic          r_ack;
   logic          r_en;
   logic          r_oneshot;
   logic          r_ien;
   logic [PW-1:0] r_presc;
   logic [PW-1:0] r_pc;
   logic          r_match;
   logic [W-1:0]  r_compare;
   logic [W-1:0]  r_count;

   logic          w_wr;
   logic          w_wrCtrl;
   logic          w_wrStatus;
   logic          w_wrCompare;
   logic          w_wrCount;
   logic          w_tick;
   logic          w_hit;
   logic [W-1:0]  w_rdt;
   logic          w_unusedDat;

   assign w_wr        = bus.i_wb_we & r_ack;
   assign w_wrCtrl    = w_wr & (bus.i_wb_adr == A_CTRL);
   assign w_wrStatus  = w_wr & (bus.i_wb_adr == A_STATUS);
   assign w_wrCompare = w_wr & (bus.i_wb_adr == A_COMPARE);
   assign w_wrCount   = w_wr & (bus.i_wb_adr == A_COUNT);
   assign w_tick      = r_en & (r_pc == r_presc);
   assign w_hit       = w_tick & (r_count == r_compare);
   assign w_unusedDat = ^{bus.i_wb_dat[7:3], bus.i_wb_dat[W-1:8+PW]};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ack <= 1'b0;
      end else begin
         r_ack <= bus.i_wb_cyc & ~r_ack;
      end
   end

   // A software CTRL write takes priority over the one-shot self-disable.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_en      <= 1'b0;
         r_oneshot <= 1'b0;
         r_ien     <= 1'b0;
         r_presc   <= '0;
      end else if (w_wrCtrl) begin
         r_en      <= bus.i_wb_dat[0];
         r_oneshot <= bus.i_wb_dat[1];
         r_ien     <= bus.i_wb_dat[2];
         r_presc   <= bus.i_wb_dat[8 +: PW];
      end else if (w_hit && r_oneshot) begin
         r_en <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pc <= '0;
      end else if (!r_en || (w_wrCtrl && !bus.i_wb_dat[0]) || w_tick) begin
         r_pc <= '0;
      end else begin
         r_pc <= r_pc + PW'(1);
      end
   end

   // A bus write to COUNT overrides both the increment and the match reload.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_count <= '0;
      end else if (w_wrCount) begin
         r_count <= bus.i_wb_dat;
      end else if (w_hit) begin
         r_count <= '0;
      end else if (w_tick) begin
         r_count <= r_count + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_compare <= '0;
      end else if (w_wrCompare) begin
         r_compare <= bus.i_wb_dat;
      end
   end

   // A new match beats a simultaneous W1C so no event is lost.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_match <= 1'b0;
      end else if (w_hit) begin
         r_match <= 1'b1;
      end else if (w_wrStatus && bus.i_wb_dat[0]) begin
         r_match <= 1'b0;
      end
   end

   always_comb begin
      w_rdt = '0;
      case (bus.i_wb_adr)
         A_CTRL: begin
            w_rdt[0]         = r_en;
            w_rdt[1]         = r_oneshot;
            w_rdt[2]         = r_ien;
            w_rdt[8 +: PW]   = r_presc;
         end
         A_STATUS:  w_rdt[0] = r_match;
         A_COMPARE: w_rdt    = r_compare;
         A_COUNT:   w_rdt    = r_count;
         default:   w_rdt    = '0;
      endcase
   end

   assign bus.o_wb_rdt = w_rdt;
   assign bus.o_wb_ack = r_ack;
   assign o_irq        = r_match & r_ien;

endmodule

// File: tb/tb_timer_irq.sv
// Directed testbench for timer_irq: bus access, prescaled counting, match/IRQ behaviour and reset.
module tb_timer_irq;

   localparam logic [1:0] A_CTRL    = 2'd0;
   localparam logic [1:0] A_STATUS  = 2'd1;
   localparam logic [1:0] A_COMPARE = 2'd2;
   localparam logic [1:0] A_COUNT   = 2'd3;

   logic clk;
   logic rstn;
   logic irq;
   int   checkCount;
   int   errorCount;

   timer_irq_if #(.W(32)) bus ();

   timer_irq #(.W(32), .PW(8)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .bus   (bus.slave),
      .o_irq (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Combinational look at a register through o_wb_rdt, without a bus cycle.
   task automatic checkReg(input string tag, input logic [1:0] adr, input logic [31:0] expected);
      bus.i_wb_adr = adr;
      #1;
      checkOutput(tag, bus.o_wb_rdt, expected);
   endtask

   task automatic waitAck(input string tag);
      int budget;
      budget = 0;
      do begin
         @(posedge clk);
         #1;
         budget++;
      end while (!bus.o_wb_ack && budget < 8);
      if (!bus.o_wb_ack) checkOutput(tag, 32'(bus.o_wb_ack), 32'd1);
   endtask

   // Full bus write; returns just after the edge on which it commits.
   task automatic applyStimulus(input logic [1:0] adr, input logic [31:0] dat);
      bus.i_wb_cyc = 1'b1;
      bus.i_wb_we  = 1'b1;
      bus.i_wb_adr = adr;
      bus.i_wb_dat = dat;
      waitAck("writeAckTimeout");
      @(posedge clk);
      #1;
      bus.i_wb_cyc = 1'b0;
      bus.i_wb_we  = 1'b0;
   endtask

   task automatic readReg(input logic [1:0] adr, output logic [31:0] dat);
      bus.i_wb_cyc = 1'b1;
      bus.i_wb_we  = 1'b0;
      bus.i_wb_adr = adr;
      waitAck("readAckTimeout");
      dat = bus.o_wb_rdt;
      bus.i_wb_cyc = 1'b0;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] rd;
   logic [31:0] expCnt3 [6];
   logic [31:0] expSts3 [6];

   initial begin
      checkCount   = 0;
      errorCount   = 0;
      rstn         = 1'b0;
      bus.i_wb_cyc = 1'b0;
      bus.i_wb_we  = 1'b0;
      bus.i_wb_adr = A_CTRL;
      bus.i_wb_dat = '0;
      expCnt3 = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd0};
      expSts3 = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};

      waitCycles(3);
      checkOutput("rstIrq", 32'(irq), 32'd0);
      checkOutput("rstAck", 32'(bus.o_wb_ack), 32'd0);
      checkReg("rstCtrl", A_CTRL, 32'd0);
      checkReg("rstCount", A_COUNT, 32'd0);
      rstn = 1'b1;
      waitCycles(1);

      $display("[TB] CTRL field layout");
      applyStimulus(A_CTRL, 32'hFFFF_FFF8);
      checkReg("ctrlUnusedBits", A_CTRL, 32'h0000_FF00);

      $display("[TB] periodic P=0 COMPARE=3");
      applyStimulus(A_COMPARE, 32'd3);
      applyStimulus(A_CTRL, 32'h0000_0005);
      checkReg("perCount0", A_COUNT, 32'd0);
      for (int k = 1; k <= 4; k++) begin
         waitCycles(1);
         checkReg($sformatf("perCount%0d", k), A_COUNT, 32'(k % 4));
         checkOutput($sformatf("perIrq%0d", k), 32'(irq), (k == 4) ? 32'd1 : 32'd0);
      end
      applyStimulus(A_STATUS, 32'd1);
      checkReg("perClrStatus", A_STATUS, 32'd0);
      checkOutput("perClrIrq", 32'(irq), 32'd0);
      waitCycles(2);
      checkReg("perMatch2", A_STATUS, 32'd1);
      checkReg("perMatch2Count", A_COUNT, 32'd0);
      checkOutput("perIrq2", 32'(irq), 32'd1);

      $display("[TB] W1C against match");
      waitCycles(2);
      applyStimulus(A_STATUS, 32'd1);
      checkReg("w1cSameEdge", A_STATUS, 32'd1);
      checkReg("w1cSameEdgeCount", A_COUNT, 32'd0);
      applyStimulus(A_STATUS, 32'd1);
      checkReg("w1cClear", A_STATUS, 32'd0);
      checkOutput("w1cClearIrq", 32'(irq), 32'd0);

      $display("[TB] one-shot COMPARE=5");
      applyStimulus(A_CTRL, 32'd0);
      applyStimulus(A_STATUS, 32'd1);
      applyStimulus(A_COUNT, 32'd0);
      applyStimulus(A_COMPARE, 32'd5);
      applyStimulus(A_CTRL, 32'h0000_0003);
      waitCycles(5);
      checkReg("osCount5", A_COUNT, 32'd5);
      checkReg("osNoMatchYet", A_STATUS, 32'd0);
      waitCycles(1);
      checkReg("osMatch", A_STATUS, 32'd1);
      checkReg("osEnCleared", A_CTRL, 32'h0000_0002);
      checkReg("osCountZero", A_COUNT, 32'd0);
      applyStimulus(A_STATUS, 32'd1);
      waitCycles(10);
      checkReg("osNoRematch", A_STATUS, 32'd0);
      checkReg("osCountHeld", A_COUNT, 32'd0);

      $display("[TB] prescaler P=1 COMPARE=2");
      applyStimulus(A_COMPARE, 32'd2);
      applyStimulus(A_CTRL, 32'h0000_0101);
      for (int k = 0; k < 6; k++) begin
         waitCycles(1);
         checkReg($sformatf("preCount%0d", k + 1), A_COUNT, expCnt3[k]);
         checkReg($sformatf("preStatus%0d", k + 1), A_STATUS, expSts3[k]);
      end

      $display("[TB] disable and resume");
      applyStimulus(A_CTRL, 32'd0);
      checkReg("disCount", A_COUNT, 32'd1);
      waitCycles(5);
      checkReg("disFrozen", A_COUNT, 32'd1);
      checkReg("disMatchKept", A_STATUS, 32'd1);
      applyStimulus(A_CTRL, 32'h0000_0101);
      waitCycles(2);
      checkReg("resumeCount", A_COUNT, 32'd2);

      $display("[TB] wrap at 2^32");
      applyStimulus(A_CTRL, 32'd0);
      applyStimulus(A_STATUS, 32'd1);
      applyStimulus(A_COMPARE, 32'h10);
      applyStimulus(A_COUNT, 32'hFFFF_FFFF);
      applyStimulus(A_CTRL, 32'h0000_0001);
      checkReg("wrapPre", A_COUNT, 32'hFFFF_FFFF);
      waitCycles(1);
      checkReg("wrapCount", A_COUNT, 32'd0);
      checkReg("wrapNoMatch", A_STATUS, 32'd0);
      waitCycles(16);
      checkReg("wrapAt10", A_COUNT, 32'h10);
      checkReg("wrapAt10Status", A_STATUS, 32'd0);
      waitCycles(1);
      checkReg("wrapMatch", A_STATUS, 32'd1);
      checkReg("wrapMatchCount", A_COUNT, 32'd0);
      applyStimulus(A_COUNT, 32'h100);
      checkReg("cntWriteWins", A_COUNT, 32'h100);
      waitCycles(1);
      checkReg("cntAfterWrite", A_COUNT, 32'h101);

      $display("[TB] async reset mid-operation");
      applyStimulus(A_CTRL, 32'd0);
      applyStimulus(A_COUNT, 32'd7);
      applyStimulus(A_CTRL, 32'h0000_0004);
      checkOutput("ienRaisesIrq", 32'(irq), 32'd1);
      checkReg("preRstCount", A_COUNT, 32'd7);
      bus.i_wb_cyc = 1'b1;
      bus.i_wb_we  = 1'b0;
      waitCycles(1);
      checkOutput("preRstAck", 32'(bus.o_wb_ack), 32'd1);
      rstn = 1'b0;
      #1;
      checkOutput("midRstIrq", 32'(irq), 32'd0);
      checkOutput("midRstAck", 32'(bus.o_wb_ack), 32'd0);
      checkReg("midRstCtrl", A_CTRL, 32'd0);
      checkReg("midRstStatus", A_STATUS, 32'd0);
      checkReg("midRstCompare", A_COMPARE, 32'd0);
      checkReg("midRstCount", A_COUNT, 32'd0);
      bus.i_wb_cyc = 1'b0;
      waitCycles(2);
      rstn = 1'b1;
      waitCycles(1);
      checkOutput("postRstIrq", 32'(irq), 32'd0);
      applyStimulus(A_COMPARE, 32'h55);
      readReg(A_COMPARE, rd);
      checkOutput("postRstBus", rd, 32'h55);
      readReg(A_COUNT, rd);
      checkOutput("postRstCount", rd, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL globalTimeout actual=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
